// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//   Time-multiplexes an 8-digit common-anode seven-segment display from one
//   32-bit packed BCD word. Each digit slot starts with a blanked guard
//   interval (anti-ghosting). A word accepted while scanning is held in a
//   one-entry pending buffer and only becomes visible at the next frame end,
//   so a frame never mixes digits from two words.
//
// Ports
//   CLK100MHZ   system clock
//   resetSW     asynchronous, active-high reset
//   load_valid  producer has a new display word
//   load_data   packed BCD, nibble k = digit k (digit 0 rightmost)
//   load_ready  controller can accept a word (pending buffer empty)
//   blank_lz    1 = blank leading zeros
//   dp_mask     bit k lights the decimal point of digit k
//   AN          digit enables, active-low
//   C           segments a..g on C[6]..C[0], active-low
//   DP          decimal point, active-low
//   scan_done   one-cycle pulse on the last cycle of each frame
module seg_scan_controller #(
    parameter int CLK_DIV    = 100_000,
    parameter int GUARD      = 2_000,
    parameter int NUM_DIGITS = 8
) (
    input  logic        CLK100MHZ,
    input  logic        resetSW,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    output logic        load_ready,
    input  logic        blank_lz,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  AN,
    output logic [6:0]  C,
    output logic        DP,
    output logic        scan_done
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD_END = CW'(GUARD - 1);
    localparam logic [2:0]    LAST_IDX  = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {S_BLANK, S_GUARD, S_ON} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [31:0]   disp, disp_n, pend, pend_n;
    logic          pend_full, pend_full_n;
    logic          accept, frame_end;

    logic [7:0]    an_n;
    logic [6:0]    c_n;
    logic          dp_n, done_n;
    logic [3:0]    nib_n;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111110;   // non-BCD nibble shows a dash
        endcase
    endfunction

    // Digit k is a leading zero if it and every scanned digit above it are 0.
    function automatic logic lz_blank(input logic [31:0] v, input logic [2:0] k);
        if (k == 3'd0) return 1'b0;
        for (int i = 0; i < 8; i++)
            if (i >= int'(k) && i < NUM_DIGITS && v[4*i +: 4] != 4'd0) return 1'b0;
        return 1'b1;
    endfunction

    assign load_ready = ~pend_full;
    assign accept     = load_valid && load_ready;
    assign frame_end  = (state == S_ON) && (idx == LAST_IDX) && (cnt == LAST_CNT);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        disp_n      = disp;
        pend_n      = pend;
        pend_full_n = pend_full;
        case (state)
            S_BLANK: begin
                // First word goes straight to the display; nothing is on screen yet.
                if (accept) begin
                    disp_n  = load_data;
                    state_n = S_GUARD;
                    cnt_n   = '0;
                    idx_n   = 3'd0;
                end
            end
            S_GUARD: begin
                cnt_n = cnt + CW'(1);
                if (cnt == GUARD_END) state_n = S_ON;
            end
            S_ON: begin
                if (cnt == LAST_CNT) begin
                    state_n = S_GUARD;
                    cnt_n   = '0;
                    idx_n   = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = S_BLANK;
        endcase
        if (state != S_BLANK) begin
            if (frame_end && pend_full) begin
                disp_n      = pend;
                pend_full_n = 1'b0;
            end
            // Pending is empty whenever accept is possible, so a word taken
            // on the frame-end edge waits for the following frame end.
            if (accept) begin
                pend_n      = load_data;
                pend_full_n = 1'b1;
            end
        end
    end

    // Outputs are computed from next-state values and registered, so the
    // pins line up with the state they describe and change on one edge.
    always_comb begin
        an_n   = 8'hFF;
        c_n    = 7'h7F;
        dp_n   = 1'b1;
        nib_n  = disp_n[{idx_n, 2'b00} +: 4];
        done_n = (state_n == S_ON) && (idx_n == LAST_IDX) && (cnt_n == LAST_CNT);
        if (state_n == S_ON) begin
            an_n = ~(8'd1 << idx_n);
            if (!(blank_lz && lz_blank(disp_n, idx_n))) begin
                c_n  = seg7(nib_n);
                dp_n = ~dp_mask[idx_n];
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge resetSW) begin
        if (resetSW) begin
            state     <= S_BLANK;
            cnt       <= '0;
            idx       <= 3'd0;
            disp      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
            AN        <= 8'hFF;
            C         <= 7'h7F;
            DP        <= 1'b1;
            scan_done <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            disp      <= disp_n;
            pend      <= pend_n;
            pend_full <= pend_full_n;
            AN        <= an_n;
            C         <= c_n;
            DP        <= dp_n;
            scan_done <= done_n;
        end
    end
endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;
    localparam int CLK_DIV = 10;
    localparam int GUARD   = 2;
    localparam int N       = 8;
    localparam int FRAME   = CLK_DIV * N;

    logic        CLK100MHZ = 1'b0;
    logic        resetSW   = 1'b1;
    logic        load_valid = 1'b0;
    logic [31:0] load_data  = '0;
    logic        blank_lz   = 1'b0;
    logic [7:0]  dp_mask    = '0;
    logic        load_ready;
    logic [7:0]  AN;
    logic [6:0]  C;
    logic        DP;
    logic        scan_done;

    seg_scan_controller #(.CLK_DIV(CLK_DIV), .GUARD(GUARD), .NUM_DIGITS(N)) dut (
        .CLK100MHZ(CLK100MHZ), .resetSW(resetSW), .load_valid(load_valid),
        .load_data(load_data), .load_ready(load_ready), .blank_lz(blank_lz),
        .dp_mask(dp_mask), .AN(AN), .C(C), .DP(DP), .scan_done(scan_done)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: time since scan start, displayed word, pending word.
    bit          m_active, m_pend_full;
    int          m_t;
    logic [31:0] m_disp, m_pend;
    logic [7:0]  e_an;
    logic [6:0]  e_c;
    logic        e_dp, e_done, e_rdy;
    logic [6:0]  seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                  7'b0000000, 7'b0000100, 7'b1111110, 7'b1111110,
                                  7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};

    function automatic void compute_exp();
        int phase, slot;
        logic [3:0] nib;
        e_rdy = !m_pend_full;
        e_an = 8'hFF; e_c = 7'h7F; e_dp = 1'b1; e_done = 1'b0;
        if (m_active) begin
            phase  = m_t % CLK_DIV;
            slot   = (m_t / CLK_DIV) % N;
            e_done = (m_t % FRAME) == FRAME - 1;
            if (phase >= GUARD) begin
                e_an = ~(8'h01 << slot);
                nib  = m_disp[4*slot +: 4];
                if (!(blank_lz && slot > 0 && (m_disp >> (4*slot)) == 32'd0)) begin
                    e_c  = seg_tab[nib];
                    e_dp = ~dp_mask[slot];
                end
            end
        end
    endfunction

    function automatic void model_reset();
        m_active = 0; m_pend_full = 0; m_t = 0; m_disp = '0; m_pend = '0;
        compute_exp();
    endfunction

    function automatic void model_edge();
        bit acc;
        if (resetSW) begin
            model_reset();
            return;
        end
        acc = load_valid && !m_pend_full;
        if (!m_active) begin
            if (acc) begin
                m_active = 1; m_t = 0; m_disp = load_data;
            end
        end else begin
            if ((m_t % FRAME) == FRAME - 1 && m_pend_full) begin
                m_disp = m_pend; m_pend_full = 0;
            end
            if (acc) begin
                m_pend = load_data; m_pend_full = 1;
            end
            m_t++;
        end
        compute_exp();
    endfunction

    task automatic tick();
        @(posedge CLK100MHZ);
        model_edge();
        #2;
    endtask

    function automatic logic [31:0] rand_word(input bit allow_err);
        logic [31:0] w;
        for (int i = 0; i < 8; i++)
            w[4*i +: 4] = allow_err ? 4'($urandom_range(15)) : 4'($urandom_range(9));
        return w;
    endfunction

    task automatic test_reset();
        @(negedge CLK100MHZ); #2;
        resetSW = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({AN, C, DP, scan_done, load_ready} !== {e_an, e_c, e_dp, e_done, e_rdy}) begin
            n_bad++;
            $display("FAIL reset_async: got AN=%h C=%b DP=%b done=%b rdy=%b want AN=%h C=%b DP=%b done=%b rdy=%b",
                     AN, C, DP, scan_done, load_ready, e_an, e_c, e_dp, e_done, e_rdy);
        end
        repeat (3) tick();
        resetSW = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_cmp++;
            if ({AN, C, DP, scan_done, load_ready} !== {e_an, e_c, e_dp, e_done, e_rdy}) begin
                n_bad++;
                $display("FAIL reset_idle cyc %0d: got AN=%h C=%b DP=%b done=%b rdy=%b want AN=%h C=%b DP=%b done=%b rdy=%b",
                         i, AN, C, DP, scan_done, load_ready, e_an, e_c, e_dp, e_done, e_rdy);
            end
        end
    endtask

    // Presents one word for a single cycle and then checks ncyc cycles.
    task automatic load_and_run(input string name, input logic [31:0] w, input int ncyc);
        load_valid = 1'b1; load_data = w;
        tick();
        load_valid = 1'b0; load_data = rand_word(1);
        n_cmp++;
        if ({AN, C, DP, scan_done, load_ready} !== {e_an, e_c, e_dp, e_done, e_rdy}) begin
            n_bad++;
            $display("FAIL %s load: got AN=%h C=%b DP=%b done=%b rdy=%b want AN=%h C=%b DP=%b done=%b rdy=%b",
                     name, AN, C, DP, scan_done, load_ready, e_an, e_c, e_dp, e_done, e_rdy);
        end
        for (int i = 0; i < ncyc; i++) begin
            tick();
            n_cmp++;
            if ({AN, C, DP, scan_done, load_ready} !== {e_an, e_c, e_dp, e_done, e_rdy}) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got AN=%h C=%b DP=%b done=%b rdy=%b want AN=%h C=%b DP=%b done=%b rdy=%b",
                         name, i, AN, C, DP, scan_done, load_ready, e_an, e_c, e_dp, e_done, e_rdy);
            end
        end
    endtask

    task automatic test_basic_scan();
        blank_lz = 1'b0; dp_mask = 8'h00;
        load_and_run("basic_scan", 32'h76543210, 2*FRAME);
    endtask

    task automatic test_frame_commit();
        repeat (30) tick();
        load_and_run("frame_commit", 32'h99999999, 2*FRAME + 10);
    endtask

    task automatic test_leading_zeros();
        blank_lz = 1'b1;
        load_and_run("lz_on", 32'h00000405, 2*FRAME);
        blank_lz = 1'b0;
        load_and_run("lz_off", 32'h00000405, FRAME);
        blank_lz = 1'b1;
        load_and_run("lz_zero", 32'h00000000, 2*FRAME);
        blank_lz = 1'b0;
    endtask

    task automatic test_error_dp();
        dp_mask = 8'h01;
        load_and_run("error_dp", 32'h0000000A, 2*FRAME);
        dp_mask = 8'h00;
    endtask

    // A word offered on the frame-end cycle must wait a full extra frame.
    task automatic test_back_to_back();
        int guard_cnt = 0;
        while (!e_done && guard_cnt < 2*FRAME) begin
            tick();
            guard_cnt++;
        end
        n_cmp++;
        if (scan_done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_frame_end: got done=%b want 1 (after %0d cycles)", scan_done, guard_cnt);
        end
        load_and_run("b2b", rand_word(0), 2*FRAME + 5);
    endtask

    task automatic test_reset_pending();
        int guard_cnt = 0;
        while (!(e_an != 8'hFF) && guard_cnt < 2*FRAME) begin
            tick();
            guard_cnt++;
        end
        load_valid = 1'b1; load_data = 32'h88888888;
        tick();
        load_valid = 1'b0;
        #2;
        resetSW = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({AN, C, DP, scan_done, load_ready} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_pending_async: got AN=%h C=%b DP=%b done=%b rdy=%b want AN=ff C=1111111 DP=1 done=0 rdy=1",
                     AN, C, DP, scan_done, load_ready);
        end
        tick();
        resetSW = 1'b0;
        for (int i = 0; i < 2*FRAME; i++) begin
            tick();
            n_cmp++;
            if ({AN, C, DP, scan_done, load_ready} !== {e_an, e_c, e_dp, e_done, e_rdy}) begin
                n_bad++;
                $display("FAIL reset_pending_idle cyc %0d: got AN=%h C=%b want AN=%h C=%b", i, AN, C, e_an, e_c);
            end
        end
        load_and_run("reset_restart", 32'h11111111, FRAME);
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            load_valid = ($urandom_range(7) == 0);
            load_data  = rand_word($urandom_range(3) == 0);
            if ((i % 10) == 0) dp_mask = 8'($urandom);
            if ((i % 97) == 0) blank_lz = 1'($urandom);
            tick();
            n_cmp++;
            if ({AN, C, DP, scan_done, load_ready} !== {e_an, e_c, e_dp, e_done, e_rdy}) begin
                n_bad++;
                $display("FAIL random cyc %0d: got AN=%h C=%b DP=%b done=%b rdy=%b want AN=%h C=%b DP=%b done=%b rdy=%b",
                         i, AN, C, DP, scan_done, load_ready, e_an, e_c, e_dp, e_done, e_rdy);
            end
        end
        load_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) tick();
        resetSW = 1'b0;
        tick();
        test_reset();
        test_basic_scan();
        test_frame_commit();
        test_leading_zeros();
        test_error_dp();
        test_back_to_back();
        test_reset_pending();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
